// File: rtl/cpu_seq_alub_hilo.sv
// rtl/cpu_seq_alub_hilo.sv - instruction-phase sequencer, ALU B-operand select and HI/LO pair
module cpu_seq_alub_hilo (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [2:0]  state,
    input  logic [1:0]  ALUSrcB,
    input  logic [31:0] register_b,
    input  logic [15:0] immediate,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic [31:0] regA,
    input  logic [63:0] muldiv_result,
    output logic [31:0] ALUB,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [1:0]  HI_LO_ALUOut
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Undefined encodings fall back to FETCH, but only on an unstalled edge.
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: state_d = S_EXEC;
                S_EXEC:   state_d = S_MEM;
                S_MEM:    state_d = S_WB;
                S_WB:     state_d = S_FETCH;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == S_EXEC && !stall && opcode == OP_SPECIAL) begin
            case (func_code)
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                    hi_d = muldiv_result[63:32];
                    lo_d = muldiv_result[31:0];
                end
                FN_MTHI: hi_d = regA;
                FN_MTLO: lo_d = regA;
                default: ;
            endcase
        end
    end

    // Logical immediates are zero-extended; everything else sign-extends.
    always_comb begin
        ALUB = register_b;
        case (ALUSrcB)
            2'b00: ALUB = register_b;
            2'b01: ALUB = 32'd4;
            2'b10: begin
                if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
                    ALUB = {16'd0, immediate};
                else
                    ALUB = {{16{immediate[15]}}, immediate};
            end
            default: ALUB = {{14{immediate[15]}}, immediate, 2'b00};
        endcase
    end

    always_comb begin
        HI_LO_ALUOut = 2'd0;
        if (opcode == OP_SPECIAL && func_code == FN_MFHI)
            HI_LO_ALUOut = 2'd1;
        else if (opcode == OP_SPECIAL && func_code == FN_MFLO)
            HI_LO_ALUOut = 2'd2;
    end

    assign state = state_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_cpu_seq_alub_hilo.sv
// tb/tb_cpu_seq_alub_hilo.sv - scoreboard bench for cpu_seq_alub_hilo
module tb_cpu_seq_alub_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  state;
    logic [1:0]  ALUSrcB;
    logic [31:0] register_b;
    logic [15:0] immediate;
    logic [5:0]  opcode;
    logic [5:0]  func_code;
    logic [31:0] regA;
    logic [63:0] muldiv_result;
    logic [31:0] ALUB;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [1:0]  HI_LO_ALUOut;

    cpu_seq_alub_hilo dut (
        .clk(clk), .reset(reset), .stall(stall), .state(state),
        .ALUSrcB(ALUSrcB), .register_b(register_b), .immediate(immediate),
        .opcode(opcode), .func_code(func_code), .regA(regA),
        .muldiv_result(muldiv_result), .ALUB(ALUB), .HI(HI), .LO(LO),
        .HI_LO_ALUOut(HI_LO_ALUOut)
    );

    always #5 clk = ~clk;

    localparam int SIG_STATE = 0;
    localparam int SIG_ALUB  = 1;
    localparam int SIG_HI    = 2;
    localparam int SIG_LO    = 3;
    localparam int SIG_SEL   = 4;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   model_st = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_sig(int sig);
        case (sig)
            SIG_STATE: return {29'd0, state};
            SIG_ALUB:  return ALUB;
            SIG_HI:    return HI;
            SIG_LO:    return LO;
            default:   return {30'd0, HI_LO_ALUOut};
        endcase
    endfunction

    // Expectations are due on the falling edge of the cycle in which they were queued.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                logic [31:0] act;
                e = q.pop_front();
                act = get_sig(e.sig);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int sig, input logic [31:0] v);
        exp_t e;
        e.name = name; e.sig = sig; e.exp = v; e.due = cyc;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reset) model_st = 0;
        else if (!stall) model_st = (model_st == 4) ? 0 : model_st + 1;
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < 8 && model_st != target; i++) step();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; ALUSrcB = 2'b00; register_b = 32'h1234_5678;
        immediate = 16'h8001; opcode = 6'h09; func_code = 6'h00; regA = 32'd0;
        muldiv_result = 64'd0;

        step(); step();
        expect_val("reset_state", SIG_STATE, 32'd0);
        expect_val("reset_hi", SIG_HI, 32'd0);
        expect_val("reset_lo", SIG_LO, 32'd0);
        step();
        reset = 1'b0;

        for (int i = 1; i <= 5; i++) begin
            step();
            expect_val($sformatf("seq_%0d", i), SIG_STATE, 32'(i % 5));
        end

        ALUSrcB = 2'b10; opcode = 6'h09;
        expect_val("alub_addiu_sext", SIG_ALUB, 32'hFFFF_8001);
        step();
        opcode = 6'h0D;
        expect_val("alub_ori_zext", SIG_ALUB, 32'h0000_8001);
        step();
        opcode = 6'h0C;
        expect_val("alub_andi_zext", SIG_ALUB, 32'h0000_8001);
        step();
        ALUSrcB = 2'b11;
        expect_val("alub_branch", SIG_ALUB, 32'hFFFE_0004);
        step();
        ALUSrcB = 2'b01;
        expect_val("alub_four", SIG_ALUB, 32'h0000_0004);
        step();
        ALUSrcB = 2'b00;
        expect_val("alub_regb", SIG_ALUB, 32'h1234_5678);
        opcode = 6'h09;

        advance_to(3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_val($sformatf("stall_mem_%0d", i), SIG_STATE, 32'd3);
        end
        stall = 1'b0;
        step();
        expect_val("stall_release", SIG_STATE, 32'd4);

        advance_to(0);
        opcode = 6'h00; func_code = 6'h18; muldiv_result = 64'h0000_0001_FFFF_FFFE;
        advance_to(2);
        expect_val("mult_pre_exec_hi", SIG_HI, 32'd0);
        step();
        expect_val("mult_hi", SIG_HI, 32'h0000_0001);
        expect_val("mult_lo", SIG_LO, 32'hFFFF_FFFE);
        func_code = 6'h10;
        expect_val("mfhi_sel", SIG_SEL, 32'd1);
        step();
        func_code = 6'h12;
        expect_val("mflo_sel", SIG_SEL, 32'd2);
        step();
        opcode = 6'h01; func_code = 6'h10;
        expect_val("sel_non_special", SIG_SEL, 32'd0);

        advance_to(0);
        opcode = 6'h00; func_code = 6'h11; regA = 32'hDEAD_BEEF;
        advance_to(3);
        expect_val("mthi_hi", SIG_HI, 32'hDEAD_BEEF);
        expect_val("mthi_lo_kept", SIG_LO, 32'hFFFF_FFFE);

        advance_to(0);
        func_code = 6'h13; regA = 32'h1234_5678;
        advance_to(3);
        expect_val("mtlo_lo", SIG_LO, 32'h1234_5678);
        expect_val("mtlo_hi_kept", SIG_HI, 32'hDEAD_BEEF);

        advance_to(0);
        func_code = 6'h1A; muldiv_result = 64'hAAAA_AAAA_BBBB_BBBB;
        advance_to(2);
        stall = 1'b1;
        step();
        expect_val("stall_exec_state", SIG_STATE, 32'd2);
        expect_val("stall_exec_hi", SIG_HI, 32'hDEAD_BEEF);
        step();
        expect_val("stall_exec_lo", SIG_LO, 32'h1234_5678);
        func_code = 6'h20;
        stall = 1'b0;
        step();
        expect_val("nonmuldiv_hi", SIG_HI, 32'hDEAD_BEEF);
        expect_val("nonmuldiv_lo", SIG_LO, 32'h1234_5678);

        advance_to(0);
        func_code = 6'h19; muldiv_result = 64'h0000_0055_0000_0066;
        advance_to(2);
        #2;
        reset = 1'b1;
        #1;
        expect_val("async_rst_state", SIG_STATE, 32'd0);
        expect_val("async_rst_hi", SIG_HI, 32'd0);
        expect_val("async_rst_lo", SIG_LO, 32'd0);
        step();
        reset = 1'b0;
        step();
        expect_val("post_rst_state", SIG_STATE, 32'd1);
        expect_val("post_rst_hi", SIG_HI, 32'd0);

        step(); step();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors += q.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
